// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO write arbiter: FSM state encoding,
// PIO register address and the HOLD dwell counter sizing.
`timescale 1ns/1ps
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } arb_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         HOLD_CNT_W    = 16;

  // Counter preload on HOLD entry: HOLD lasts max(1, hold_cycles) cycles.
  function automatic logic [HOLD_CNT_W-1:0] hold_load(input int unsigned hold_cycles);
    if (hold_cycles > 32'd1) begin
      return HOLD_CNT_W'(hold_cycles - 32'd1);
    end else begin
      return {HOLD_CNT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request searching upward from
// last_grant+1 with wrap-around; returns one-hot grant and its index.
`timescale 1ns/1ps
module rr_arbiter_comb #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_req
);

  logic           found_s;
  logic [IDW-1:0] cand_s;

  // Rotating priority search; the first hit after the pointer wins.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {IDW{1'b0}};
    found_s   = 1'b0;
    cand_s    = {IDW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDW'((int'(last_grant) + i) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        found_s        = 1'b1;
        grant[cand_s]  = 1'b1;
        grant_idx      = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin sharing of one output-PIO data register among NUM_REQ requesters.
// Optional read-back check of every write is built when PIO_ARB_READBACK_EN is defined.
`timescale 1ns/1ps
module pio_write_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic [NUM_REQ-1:0]                              req,
  input  logic [NUM_REQ*DATA_W-1:0]                       req_data,
  output logic [NUM_REQ-1:0]                              ack,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                            busy,
  output logic [1:0]                                      m_address,
  output logic                                            m_chipselect,
  output logic                                            m_write_n,
  output logic [31:0]                                     m_writedata,
  input  logic [31:0]                                     m_readdata,
  input  logic                                            err_clr,
  output logic                                            err
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e              state_r, state_s;
  logic [IDW-1:0]          last_grant_r, last_grant_s;
  logic [IDW-1:0]          grant_id_r, grant_id_s;
  logic [DATA_W-1:0]       data_r, data_s;
  logic [HOLD_CNT_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [NUM_REQ-1:0]      ack_r, ack_s;
  logic                    cs_r, cs_s;
  logic                    wn_r, wn_s;
  logic                    busy_r, busy_s;
  logic [31:0]             wd_r, wd_s;

  logic [NUM_REQ-1:0]      arb_grant_s;
  logic [IDW-1:0]          arb_idx_s;
  logic                    arb_any_s;
  logic                    unused_s;

  rr_arbiter_comb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .grant_idx  (arb_idx_s),
    .any_req    (arb_any_s)
  );

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    grant_id_s   = grant_id_r;
    data_s       = data_r;
    hold_cnt_s   = hold_cnt_r;
    wd_s         = wd_r;
    ack_s        = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (arb_any_s) begin
          state_s      = WRITE;
          grant_id_s   = arb_idx_s;
          last_grant_s = arb_idx_s;
          data_s       = req_data[int'(arb_idx_s)*DATA_W +: DATA_W];
          wd_s         = {32{1'b0}};
          wd_s[DATA_W-1:0] = req_data[int'(arb_idx_s)*DATA_W +: DATA_W];
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
`ifdef PIO_ARB_READBACK_EN
        state_s = READ;
`else
        state_s             = HOLD;
        ack_s[grant_id_r]   = 1'b1;
        hold_cnt_s          = hold_load(HOLD_CYCLES);
`endif
      end
      READ: begin
`ifdef PIO_ARB_READBACK_EN
        state_s             = HOLD;
        ack_s[grant_id_r]   = 1'b1;
        hold_cnt_s          = hold_load(HOLD_CYCLES);
`else
        state_s = IDLE;
`endif
      end
      HOLD: begin
        if (hold_cnt_r == {HOLD_CNT_W{1'b0}}) begin
          state_s = IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    cs_s   = (state_s == WRITE) || (state_s == READ);
    wn_s   = (state_s != WRITE);
    busy_s = (state_s != IDLE);
  end

  // State, latched transaction and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NUM_REQ - 1);
      grant_id_r   <= {IDW{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      hold_cnt_r   <= {HOLD_CNT_W{1'b0}};
      ack_r        <= {NUM_REQ{1'b0}};
      cs_r         <= 1'b0;
      wn_r         <= 1'b1;
      busy_r       <= 1'b0;
      wd_r         <= {32{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      grant_id_r   <= grant_id_s;
      data_r       <= data_s;
      hold_cnt_r   <= hold_cnt_s;
      ack_r        <= ack_s;
      cs_r         <= cs_s;
      wn_r         <= wn_s;
      busy_r       <= busy_s;
      wd_r         <= wd_s;
    end
  end

`ifdef PIO_ARB_READBACK_EN
  logic err_r, err_s;

  // Sticky read-back mismatch; a new mismatch beats a same-cycle clear.
  always_comb begin
    err_s = err_r;
    if ((state_r == READ) && (m_readdata[DATA_W-1:0] != data_r)) begin
      err_s = 1'b1;
    end else if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign ack          = ack_r;
  assign grant_id     = grant_id_r;
  assign busy         = busy_r;
  assign m_address    = PIO_DATA_ADDR;
  assign m_chipselect = cs_r;
  assign m_write_n    = wn_r;
  assign m_writedata  = wd_r;

  // Bits that only matter in some configurations.
  assign unused_s = ^{arb_grant_s, m_readdata, err_clr};

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: directed requests push expected writes/acks,
// a negedge monitor pops and compares. Read-back checks follow PIO_ARB_READBACK_EN.
`timescale 1ns/1ps
module tb_pio_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
`ifdef PIO_ARB_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef struct {
    logic [3:0] ack;
    logic [1:0] gid;
  } ack_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req_a, ack_a, req_b, ack_b;
  logic [31:0] req_data_a, req_data_b;
  logic [1:0]  gid_a, gid_b, addr_a, addr_b;
  logic        busy_a, busy_b, cs_a, cs_b, wn_a, wn_b;
  logic [31:0] wd_a, wd_b, rd_a, rd_b;
  logic        err_clr_a, err_clr_b, err_a, err_b;
  logic [31:0] pio_reg_a;
  logic        force_bad;

  logic [31:0] exp_wr_q[$];
  ack_t        exp_ack_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  pio_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .req_data(req_data_a), .ack(ack_a),
    .grant_id(gid_a), .busy(busy_a), .m_address(addr_a), .m_chipselect(cs_a),
    .m_write_n(wn_a), .m_writedata(wd_a), .m_readdata(rd_a), .err_clr(err_clr_a), .err(err_a)
  );

  pio_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .req_data(req_data_b), .ack(ack_b),
    .grant_id(gid_b), .busy(busy_b), .m_address(addr_b), .m_chipselect(cs_b),
    .m_write_n(wn_b), .m_writedata(wd_b), .m_readdata(rd_b), .err_clr(err_clr_b), .err(err_b)
  );

  // PIO slave model: data register written on strobe, zero-latency readdata.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pio_reg_a <= 32'd0;
    else if (cs_a && !wn_a) pio_reg_a <= wd_a;
  end
  assign rd_a = force_bad ? 32'h0000_005A : pio_reg_a;
  assign rd_b = wd_b;
  assign err_clr_b = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic expect_txn(input logic [31:0] data, input int idx);
    ack_t a;
    a.ack = 4'b0001 << idx;
    a.gid = 2'(idx);
    exp_wr_q.push_back(data);
    exp_ack_q.push_back(a);
  endtask

  // Monitor: every write strobe and every ack must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cs_a && !wn_a) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got 0x%0h expected none", wd_a);
        end else begin
          check("wr_data", wd_a, exp_wr_q.pop_front());
          check("wr_addr", {30'd0, addr_a}, 32'd0);
        end
      end
      if (ack_a != 4'd0) begin
        if (exp_ack_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack: got 0x%0h expected none", ack_a);
        end else begin
          ack_t e;
          e = exp_ack_q.pop_front();
          check("ack_vec", {28'd0, ack_a}, {28'd0, e.ack});
          check("ack_gid", {30'd0, gid_a}, {30'd0, e.gid});
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    req_a = 4'd0;
    req_b = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_acks(input int n, input bit drop, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ack_a != 4'd0) begin
        got++;
        if (drop) req_a = req_a & ~ack_a;
      end
    end
    check("ack_count", 32'(got), 32'(n));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
    check({tag, "_ack_q_empty"}, 32'(exp_ack_q.size()), 32'd0);
  endtask

  initial begin
    int lat, strobe_cyc, k, holds, idles;
    int s_cyc[2];
    logic [1:0] s_gid[2];
    logic [31:0] s_wd[2];
    req_a = 4'd0; req_b = 4'd0; req_data_a = 32'd0; req_data_b = 32'd0;
    err_clr_a = 1'b0; force_bad = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_ack", {28'd0, ack_a}, 32'd0);
    check("rst_gid", {30'd0, gid_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_cs", {31'd0, cs_a}, 32'd0);
    check("rst_wn", {31'd0, wn_a}, 32'd1);
    check("rst_wd", wd_a, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    do_reset();

    // Single request from requester 2
    expect_txn(32'h0000_00A5, 2);
    req_data_a[23:16] = 8'hA5;
    req_a = 4'b0100;
    lat = 0; strobe_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cs_a && !wn_a) strobe_cyc = c;
      if (ack_a[2]) begin
        lat = c;
        break;
      end
    end
    req_a = 4'd0;
    check("strobe_latency", 32'(strobe_cyc), 32'd1);
    check("ack_latency", 32'(lat), 32'(2 + RB));
    check("single_gid", {30'd0, gid_a}, 32'd2);
    check("single_busy", {31'd0, busy_a}, 32'd1);
    repeat (4) @(negedge clk);
    check("idle_busy", {31'd0, busy_a}, 32'd0);
    check_drained("single");

    // All four held: strict rotation from requester 0
    do_reset();
    req_data_a = 32'h4433_2211;
    expect_txn(32'h11, 0); expect_txn(32'h22, 1); expect_txn(32'h33, 2);
    expect_txn(32'h44, 3); expect_txn(32'h11, 0);
    req_a = 4'hF;
    wait_acks(5, 1'b0, 60);
    req_a = 4'd0;
    repeat (5) @(negedge clk);
    check_drained("rotate");

    // Reset asserted during WRITE, then requester 0 wins first
    req_data_a = 32'h0000_3C00;
    exp_wr_q.push_back(32'h3C);
    req_a = 4'b0010;
    @(negedge clk);
    #2 reset_n = 1'b0;
    req_a = 4'd0;
    #1;
    check("mid_rst_cs", {31'd0, cs_a}, 32'd0);
    check("mid_rst_wn", {31'd0, wn_a}, 32'd1);
    check("mid_rst_ack", {28'd0, ack_a}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    req_data_a = 32'h0000_6655;
    expect_txn(32'h55, 0); expect_txn(32'h66, 1);
    req_a = 4'b0011;
    wait_acks(2, 1'b1, 30);
    req_a = 4'd0;
    repeat (5) @(negedge clk);
    check_drained("after_rst");

    // Requester 1 pulses for one cycle while 0 is in service
    req_data_a = 32'h0000_9977;
    expect_txn(32'h77, 0);
    req_a = 4'b0001;
    @(negedge clk);
    req_a[1] = 1'b1;
    @(negedge clk);
    req_a[1] = 1'b0;
    if (ack_a == 4'd0) wait_acks(1, 1'b1, 10);
    req_a = 4'd0;
    repeat (8) @(negedge clk);
    check_drained("withdraw");

    // HOLD_CYCLES=3 dwell between back-to-back writes
    req_data_b = 32'hD4C3_B2A1;
    req_b = 4'b0011;
    k = 0; holds = 0; idles = 0;
    for (int c = 1; c <= 40 && k < 2; c++) begin
      @(negedge clk);
      if (cs_b && !wn_b) begin
        s_cyc[k] = c; s_gid[k] = gid_b; s_wd[k] = wd_b;
        k++;
      end else if (k == 1 && busy_b && !cs_b) begin
        holds++;
      end else if (k == 1 && !busy_b) begin
        idles++;
      end
    end
    req_b = 4'd0;
    check("dwell_strobes", 32'(k), 32'd2);
    if (k == 2) begin
      check("dwell_period", 32'(s_cyc[1] - s_cyc[0]), 32'(5 + RB));
      check("dwell_gid0", {30'd0, s_gid[0]}, 32'd0);
      check("dwell_gid1", {30'd0, s_gid[1]}, 32'd1);
      check("dwell_wd1", s_wd[1], 32'hB2);
    end
    check("dwell_hold_cycles", 32'(holds), 32'd3);
    check("dwell_idle_cycles", 32'(idles), 32'd1);

    // Read-back mismatch and error clear
    force_bad = 1'b1;
    req_data_a = 32'h00A5_0000;
    expect_txn(32'hA5, 2);
    req_a = 4'b0100;
    wait_acks(1, 1'b1, 10);
    force_bad = 1'b0;
    @(negedge clk);
    check("err_after_read", {31'd0, err_a}, 32'(RB));
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
    @(negedge clk);
    check("err_after_clr", {31'd0, err_a}, 32'd0);
    repeat (3) @(negedge clk);
    check_drained("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
